// File: rtl/pkt_frame_pkg.sv
// Shared types and constants for the packet frame checker.
// A frame is a header word {seq, len}, len payload words, then a footer word.
package pkt_frame_pkg;

   typedef enum logic [1:0] {
      ST_HDR  = 2'd0,
      ST_PAY  = 2'd1,
      ST_FTR  = 2'd2,
      ST_DROP = 2'd3
   } frame_state_t;

   localparam int unsigned  MAX_LEN_DEFAULT     = 100;
   localparam logic [31:0]  FOOTER_WORD_DEFAULT = 32'hFFFF_FFFF;

   localparam int unsigned  SEQ_MSB = 31;
   localparam int unsigned  SEQ_LSB = 16;
   localparam int unsigned  LEN_MSB = 15;
   localparam int unsigned  LEN_LSB = 0;

endpackage

// File: rtl/sat_counter.sv
// Increment-enable counter that sticks at its all-ones value.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/packet_frame_checker.sv
// Checks framing, length, footer and sequence of incoming frames, strips
// header/footer, forwards payload and reports per-frame status and counters.
module packet_frame_checker
   import pkt_frame_pkg::*;
#(
   parameter int unsigned MAX_LEN     = MAX_LEN_DEFAULT,
   parameter logic [31:0] FOOTER_WORD = FOOTER_WORD_DEFAULT,
   parameter logic [15:0] SEQ_INIT    = 16'h0001
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        validIn,
   input  logic [31:0] dataIn,
   input  logic        lastIn,
   output logic        validOut,
   output logic [31:0] dataOut,
   output logic        lastOut,
   output logic        pktDone,
   output logic        pktOk,
   output logic        errLen,
   output logic        errSeq,
   output logic        errFooter,
   output logic [15:0] pktCount,
   output logic [15:0] errCount
);

   localparam logic [15:0] LEN_LIMIT = 16'(MAX_LEN);

   frame_state_t r_state;
   logic [15:0]  r_expSeq;
   logic [15:0]  r_remaining;
   logic         r_errLen;
   logic         r_errSeq;
   logic         r_errFooter;

   logic [15:0]  w_seq;
   logic [15:0]  w_len;
   logic         w_term;
   logic         w_eLen;
   logic         w_eSeq;
   logic         w_eFtr;
   logic         w_bad;

   assign w_seq = dataIn[SEQ_MSB:SEQ_LSB];
   assign w_len = dataIn[LEN_MSB:LEN_LSB];

   // Error flags as they stand including this cycle's word, so a frame that
   // terminates now reports detections made on its final word.
   always_comb begin
      w_term = 1'b0;
      w_eLen = r_errLen;
      w_eSeq = r_errSeq;
      w_eFtr = r_errFooter;
      if (validIn) begin
         unique case (r_state)
            ST_HDR: begin
               w_eSeq = (w_seq != r_expSeq);
               w_eLen = lastIn || (w_len > LEN_LIMIT);
               w_eFtr = 1'b0;
               w_term = lastIn;
            end
            ST_PAY: begin
               if (lastIn) begin
                  w_eLen = 1'b1;
                  w_term = 1'b1;
               end
            end
            ST_FTR: begin
               if (!lastIn) begin
                  w_eLen = 1'b1;
               end else begin
                  w_eFtr = (dataIn != FOOTER_WORD);
                  w_term = 1'b1;
               end
            end
            ST_DROP: begin
               w_term = lastIn;
            end
         endcase
      end
   end

   assign w_bad = w_eLen | w_eSeq | w_eFtr;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_HDR;
         r_expSeq    <= SEQ_INIT;
         r_remaining <= '0;
         r_errLen    <= 1'b0;
         r_errSeq    <= 1'b0;
         r_errFooter <= 1'b0;
         validOut    <= 1'b0;
         dataOut     <= '0;
         lastOut     <= 1'b0;
         pktDone     <= 1'b0;
         pktOk       <= 1'b0;
         errLen      <= 1'b0;
         errSeq      <= 1'b0;
         errFooter   <= 1'b0;
      end else begin
         validOut  <= 1'b0;
         lastOut   <= 1'b0;
         pktDone   <= w_term;
         pktOk     <= w_term & ~w_bad;
         errLen    <= w_term & w_eLen;
         errSeq    <= w_term & w_eSeq;
         errFooter <= w_term & w_eFtr;

         if (w_term) begin
            r_errLen    <= 1'b0;
            r_errSeq    <= 1'b0;
            r_errFooter <= 1'b0;
         end else begin
            r_errLen    <= w_eLen;
            r_errSeq    <= w_eSeq;
            r_errFooter <= w_eFtr;
         end

         if (validIn) begin
            unique case (r_state)
               ST_HDR: begin
                  r_expSeq <= w_seq + 16'd1;
                  if (lastIn) begin
                     r_state <= ST_HDR;
                  end else if (w_len > LEN_LIMIT) begin
                     r_state <= ST_DROP;
                  end else if (w_len == 16'd0) begin
                     r_state <= ST_FTR;
                  end else begin
                     r_remaining <= w_len;
                     r_state     <= ST_PAY;
                  end
               end
               ST_PAY: begin
                  if (lastIn) begin
                     r_state <= ST_HDR;
                  end else begin
                     validOut    <= 1'b1;
                     dataOut     <= dataIn;
                     r_remaining <= r_remaining - 16'd1;
                     if (r_remaining == 16'd1) begin
                        lastOut <= 1'b1;
                        r_state <= ST_FTR;
                     end
                  end
               end
               ST_FTR: begin
                  r_state <= lastIn ? ST_HDR : ST_DROP;
               end
               ST_DROP: begin
                  if (lastIn) begin
                     r_state <= ST_HDR;
                  end
               end
            endcase
         end
      end
   end

   sat_counter #(.WIDTH(16)) u_pkt_cnt (
      .clk     (clk),
      .resetn  (resetn),
      .i_inc   (w_term),
      .o_count (pktCount)
   );

   sat_counter #(.WIDTH(16)) u_err_cnt (
      .clk     (clk),
      .resetn  (resetn),
      .i_inc   (w_term & w_bad),
      .o_count (errCount)
   );

endmodule
